// File: rtl/prim_fifo_arb_pkg.sv
// Shared types and helpers for the async-FIFO write-port arbiter.
package prim_fifo_arb_pkg;

  // Arbiter FSM: free to pick a new packet, or locked to the current owner.
  typedef enum logic {
    ArbIdle   = 1'b0,
    ArbLocked = 1'b1
  } arb_state_e;

  // Width of the source tag carried with every beat (at least one bit).
  function automatic int idx_width(input int num_req);
    return (num_req <= 2) ? 1 : $clog2(num_req);
  endfunction

endpackage

// File: rtl/prim_fifo_async_wr_arb_if.sv
// Requester and FIFO write-port bundle for prim_fifo_async_wr_arb.
//
// Handshake: a requester raises req_i[k] with last_i[k] and its data slice and
// holds them stable until gnt_o[k] is high. A beat moves into the FIFO in any
// cycle where fifo_wvalid_o && fifo_wready_i; gnt_o reports which requester
// that beat came from.
interface prim_fifo_async_wr_arb_if #(
  parameter int NumReq = 4,
  parameter int Width  = 16,
  parameter int DepthW = 2,
  parameter int IdxW   = prim_fifo_arb_pkg::idx_width(NumReq)
);
  logic [NumReq-1:0]       req_i;
  logic [NumReq-1:0]       last_i;
  logic [NumReq*Width-1:0] data_i;
  logic [NumReq-1:0]       gnt_o;
  logic                    fifo_wvalid_o;
  logic                    fifo_wready_i;
  logic [IdxW+Width-1:0]   fifo_wdata_o;
  logic [DepthW-1:0]       fifo_wdepth_i;

  // Arbiter side.
  modport slave (
    input  req_i, last_i, data_i, fifo_wready_i, fifo_wdepth_i,
    output gnt_o, fifo_wvalid_o, fifo_wdata_o
  );

  // Environment side: requesters plus the FIFO write port.
  modport master (
    output req_i, last_i, data_i, fifo_wready_i, fifo_wdepth_i,
    input  gnt_o, fifo_wvalid_o, fifo_wdata_o
  );
endinterface

// File: rtl/prim_rr_pick.sv
// Combinational round-robin pick: first set request at or above ptr_i, with wrap.
module prim_rr_pick
  import prim_fifo_arb_pkg::*;
#(
  parameter int NumReq = 4,
  parameter int IdxW   = idx_width(NumReq)
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic [IdxW-1:0]   idx_o,
  output logic              any_o
);

  int   cand;
  logic found;

  // Scan NumReq positions starting at the pointer and keep the first hit.
  always_comb begin
    idx_o = '0;
    found = 1'b0;
    cand  = 0;
    for (int i = 0; i < NumReq; i++) begin
      cand = (int'(ptr_i) + i) % NumReq;
      if (!found && req_i[cand]) begin
        found = 1'b1;
        idx_o = IdxW'(cand);
      end
    end
    any_o = |req_i;
  end

endmodule

// File: rtl/prim_fifo_async_wr_arb.sv
// Shares one async-FIFO write port among NumReq requesters. Round-robin at
// packet granularity, port locked to the winner until its last beat, new
// packet starts throttled by the FIFO write-side depth, each beat tagged
// with its source index.
module prim_fifo_async_wr_arb
  import prim_fifo_arb_pkg::*;
#(
  parameter int NumReq      = 4,
  parameter int Width       = 16,
  parameter int DepthW      = 2,
  parameter int HiWatermark = 2,
  localparam int IdxW       = idx_width(NumReq)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  prim_fifo_async_wr_arb_if.slave       bus,
  output logic                          locked_o,
  output logic [IdxW-1:0]               owner_o,
  output logic [15:0]                   pkt_cnt_o
);

  arb_state_e        state_q;
  logic [IdxW-1:0]   ptr_q;
  logic [IdxW-1:0]   owner_q;
  logic [15:0]       pkt_cnt_q;

  logic [IdxW-1:0]   pick_idx;
  logic              pick_any;
  logic [IdxW-1:0]   sel;
  logic [IdxW-1:0]   sel_inc;
  logic              sel_req;
  logic              sel_last;
  logic [Width-1:0]  sel_data;
  logic              wvalid;
  logic              xfer;

  prim_rr_pick #(
    .NumReq (NumReq),
    .IdxW   (IdxW)
  ) u_pick (
    .req_i (bus.req_i),
    .ptr_i (ptr_q),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // Selection, per-source muxing and the write-valid/grant decode.
  always_comb begin
    sel      = (state_q == ArbLocked) ? owner_q : pick_idx;
    sel_inc  = (sel == IdxW'(NumReq - 1)) ? '0 : sel + 1'b1;
    sel_req  = 1'b0;
    sel_last = 1'b0;
    sel_data = '0;
    for (int k = 0; k < NumReq; k++) begin
      if (sel == IdxW'(k)) begin
        sel_req  = bus.req_i[k];
        sel_last = bus.last_i[k];
        sel_data = bus.data_i[k*Width +: Width];
      end
    end
    // The watermark only gates packet starts; a locked packet always drains.
    if (state_q == ArbLocked) begin
      wvalid = sel_req;
    end else begin
      wvalid = pick_any && (int'(bus.fifo_wdepth_i) < HiWatermark);
    end
    // Nothing is offered while reset is held.
    wvalid = wvalid && rst_ni;
    xfer   = wvalid && bus.fifo_wready_i;
    bus.gnt_o = '0;
    for (int k = 0; k < NumReq; k++) begin
      if (xfer && (sel == IdxW'(k))) begin
        bus.gnt_o[k] = 1'b1;
      end
    end
  end

  assign bus.fifo_wvalid_o = wvalid;
  assign bus.fifo_wdata_o  = {sel, sel_data};

  // Packet FSM with rr pointer, owner and completed-packet counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ArbIdle;
      ptr_q     <= '0;
      owner_q   <= '0;
      pkt_cnt_q <= '0;
    end else if (xfer) begin
      owner_q <= sel;
      unique case (state_q)
        ArbIdle: begin
          if (sel_last) begin
            ptr_q     <= sel_inc;
            pkt_cnt_q <= pkt_cnt_q + 16'd1;
          end else begin
            state_q <= ArbLocked;
          end
        end
        ArbLocked: begin
          if (sel_last) begin
            state_q   <= ArbIdle;
            ptr_q     <= sel_inc;
            pkt_cnt_q <= pkt_cnt_q + 16'd1;
          end
        end
        default: state_q <= ArbIdle;
      endcase
    end
  end

  assign locked_o  = (state_q == ArbLocked);
  assign owner_o   = owner_q;
  assign pkt_cnt_o = pkt_cnt_q;

endmodule
